// File: rtl/bullet_pool.sv
// Slot-allocated projectile store: lowest-free-slot fire allocation, tick-driven
// movement and retirement, and a valid/ready scan port feeding the plotter.
module bullet_pool #(
    parameter int NUM_BULLETS = 8,
    parameter int SLOT_W      = 3,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int X_MAX       = 159,
    parameter int Y_MAX       = 119,
    parameter int MOVE_DIV    = 10,
    parameter int LIFETIME    = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fire,
    input  logic [X_W-1:0]         fire_x,
    input  logic [Y_W-1:0]         fire_y,
    input  logic [1:0]             fire_dx,
    input  logic [1:0]             fire_dy,
    output logic                   fire_ack,
    output logic [SLOT_W-1:0]      fire_slot,
    output logic                   fire_drop,
    input  logic                   kill,
    input  logic [SLOT_W-1:0]      kill_slot,
    output logic [NUM_BULLETS-1:0] active,
    output logic                   full,
    input  logic                   scan_start,
    output logic                   scan_busy,
    output logic                   plot_valid,
    input  logic                   plot_ready,
    output logic [X_W-1:0]         plot_x,
    output logic [Y_W-1:0]         plot_y,
    output logic [SLOT_W-1:0]      plot_slot,
    output logic                   scan_done
);
    localparam int                CNT_W     = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MOVE_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_BULLETS - 1);
    localparam logic [X_W-1:0]    XM        = X_W'(X_MAX);
    localparam logic [Y_W-1:0]    YM        = Y_W'(Y_MAX);
    localparam logic [7:0]        LIFE_INIT = 8'(LIFETIME);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT} scan_state_t;

    logic [X_W-1:0]         pos_x  [NUM_BULLETS];
    logic [Y_W-1:0]         pos_y  [NUM_BULLETS];
    logic [1:0]             dir_x  [NUM_BULLETS];
    logic [1:0]             dir_y  [NUM_BULLETS];
    logic [7:0]             life   [NUM_BULLETS];
    logic [CNT_W-1:0]       cnt;
    logic                   tick;
    logic                   free_found;
    logic [SLOT_W-1:0]      free_idx;
    logic                   fire_ok;
    logic [NUM_BULLETS-1:0] fire_grant;
    logic [NUM_BULLETS-1:0] kill_hit;
    logic [NUM_BULLETS-1:0] edge_hit;
    scan_state_t            state, state_n;
    logic [SLOT_W-1:0]      idx, idx_n;
    logic                   capture, done_n;

    function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] v, input logic [1:0] d);
        case (d)
            2'b01:   step_x = v + X_W'(1);
            2'b10:   step_x = v - X_W'(1);
            default: step_x = v;
        endcase
    endfunction

    function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] v, input logic [1:0] d);
        case (d)
            2'b01:   step_y = v + Y_W'(1);
            2'b10:   step_y = v - Y_W'(1);
            default: step_y = v;
        endcase
    endfunction

    assign tick = (cnt == CNT_LAST);
    assign full = &active;

    always_ff @(posedge clk) begin
        if (reset || tick) cnt <= '0;
        else               cnt <= cnt + CNT_W'(1);
    end

    // Allocation looks only at the registered active bits, so a slot freed this cycle is not reused until the next.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        fire_grant = '0;
        for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            if (!active[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
        fire_ok = fire && free_found && (fire_x <= XM) && (fire_y <= YM);
        for (int unsigned i = 0; i < NUM_BULLETS; i++)
            fire_grant[i] = fire_ok && (free_idx == SLOT_W'(i));
    end

    always_comb begin
        kill_hit = '0;
        edge_hit = '0;
        for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            kill_hit[i] = kill && active[i] && (kill_slot == SLOT_W'(i));
            edge_hit[i] = (pos_x[i] == '0 && dir_x[i] == 2'b10) || (pos_x[i] == XM && dir_x[i] == 2'b01)
                       || (pos_y[i] == '0 && dir_y[i] == 2'b10) || (pos_y[i] == YM && dir_y[i] == 2'b01);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= '0;
            for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                dir_x[i] <= '0;
                dir_y[i] <= '0;
                life[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
                if (active[i]) begin
                    if (kill_hit[i]) begin
                        active[i] <= 1'b0;
                    end else if (tick) begin
                        if (life[i] == '0 || edge_hit[i]) begin
                            active[i] <= 1'b0;
                        end else begin
                            pos_x[i] <= step_x(pos_x[i], dir_x[i]);
                            pos_y[i] <= step_y(pos_y[i], dir_y[i]);
                            life[i]  <= life[i] - 8'd1;
                        end
                    end
                end else if (fire_grant[i]) begin
                    active[i] <= 1'b1;
                    pos_x[i]  <= fire_x;
                    pos_y[i]  <= fire_y;
                    dir_x[i]  <= fire_dx;
                    dir_y[i]  <= fire_dy;
                    life[i]   <= LIFE_INIT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fire_ack  <= 1'b0;
            fire_drop <= 1'b0;
            fire_slot <= '0;
        end else begin
            fire_ack  <= fire_ok;
            fire_drop <= fire && !fire_ok;
            fire_slot <= fire_ok ? free_idx : '0;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        capture = 1'b0;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (scan_start) begin
                    state_n = S_SCAN;
                    idx_n   = '0;
                end
            end
            S_SCAN: begin
                if (active[idx]) begin
                    capture = 1'b1;
                    state_n = S_WAIT;
                end else if (idx == SLOT_LAST) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else begin
                    idx_n = idx + SLOT_W'(1);
                end
            end
            S_WAIT: begin
                if (plot_ready) begin
                    if (idx == SLOT_LAST) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_SCAN;
                        idx_n   = idx + SLOT_W'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            scan_done <= 1'b0;
            plot_x    <= '0;
            plot_y    <= '0;
            plot_slot <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            scan_done <= done_n;
            if (capture) begin
                plot_x    <= pos_x[idx];
                plot_y    <= pos_y[idx];
                plot_slot <= idx;
            end
        end
    end

    assign plot_valid = (state == S_WAIT);
    assign scan_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: allocation, movement, retirement and scan handshake.
module tb_bullet_pool;
    logic       clk = 1'b0;
    logic       reset, fire, kill, scan_start, plot_ready;
    logic [7:0] fire_x;
    logic [6:0] fire_y;
    logic [1:0] fire_dx, fire_dy;
    logic [2:0] kill_slot;
    logic       fire_ack, fire_drop, full, scan_busy, plot_valid, scan_done;
    logic [2:0] fire_slot, plot_slot;
    logic [7:0] active, plot_x;
    logic [6:0] plot_y;
    logic       l_fire_ack, l_fire_drop, l_full, l_scan_busy, l_plot_valid, l_scan_done;
    logic [2:0] l_fire_slot, l_plot_slot;
    logic [7:0] l_active, l_plot_x;
    logic [6:0] l_plot_y;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bullet_pool #(.NUM_BULLETS(8), .SLOT_W(3), .LIFETIME(64)) dut (
        .clk(clk), .reset(reset), .fire(fire), .fire_x(fire_x), .fire_y(fire_y),
        .fire_dx(fire_dx), .fire_dy(fire_dy), .fire_ack(fire_ack), .fire_slot(fire_slot),
        .fire_drop(fire_drop), .kill(kill), .kill_slot(kill_slot), .active(active), .full(full),
        .scan_start(scan_start), .scan_busy(scan_busy), .plot_valid(plot_valid),
        .plot_ready(plot_ready), .plot_x(plot_x), .plot_y(plot_y), .plot_slot(plot_slot),
        .scan_done(scan_done));

    // Short-lifetime instance shares the stimulus; only its active bits are examined.
    bullet_pool #(.NUM_BULLETS(8), .SLOT_W(3), .LIFETIME(4)) dut_life (
        .clk(clk), .reset(reset), .fire(fire), .fire_x(fire_x), .fire_y(fire_y),
        .fire_dx(fire_dx), .fire_dy(fire_dy), .fire_ack(l_fire_ack), .fire_slot(l_fire_slot),
        .fire_drop(l_fire_drop), .kill(kill), .kill_slot(kill_slot), .active(l_active), .full(l_full),
        .scan_start(scan_start), .scan_busy(l_scan_busy), .plot_valid(l_plot_valid),
        .plot_ready(plot_ready), .plot_x(l_plot_x), .plot_y(l_plot_y), .plot_slot(l_plot_slot),
        .scan_done(l_scan_done));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic idle_inputs();
        fire = 0; fire_x = '0; fire_y = '0; fire_dx = '0; fire_dy = '0;
        kill = 0; kill_slot = '0; scan_start = 0; plot_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        cyc = 0;
    endtask

    task automatic shoot(input int x, input int y, input logic [1:0] dx, input logic [1:0] dy);
        fire = 1; fire_x = 8'(x); fire_y = 7'(y); fire_dx = dx; fire_dy = dy;
        step();
        fire = 0;
    endtask

    task automatic wait_valid(output logic ok);
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (plot_valid) begin ok = 1; break; end
            step();
        end
    endtask

    task automatic wait_done(output logic ok, output int nvalid);
        ok = 0;
        nvalid = 0;
        for (int k = 0; k < 40; k++) begin
            if (scan_done) begin ok = 1; break; end
            if (plot_valid) nvalid++;
            step();
        end
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        checks++;
        if (active !== 8'h00 || full !== 0 || fire_ack !== 0 || fire_drop !== 0 || fire_slot !== 0 ||
            scan_busy !== 0 || plot_valid !== 0 || scan_done !== 0 || plot_x !== 0 || plot_y !== 0 || plot_slot !== 0) begin
            $display("FAIL reset_state: active=%h full=%b ack=%b drop=%b busy=%b valid=%b done=%b, required all 0",
                     active, full, fire_ack, fire_drop, scan_busy, plot_valid, scan_done);
            errors++;
        end
        shoot(30, 30, 2'b00, 2'b00);
        scan_start = 1;
        step();
        scan_start = 0;
        step();
        reset = 1;
        step();
        reset = 0;
        cyc = 0;
        checks++;
        if (plot_valid !== 0 || scan_busy !== 0 || scan_done !== 0 || active !== 8'h00) begin
            $display("FAIL reset_abort: valid=%b busy=%b done=%b active=%h, required 0 0 0 00",
                     plot_valid, scan_busy, scan_done, active);
            errors++;
        end
        n = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (scan_done) n++;
        end
        checks++;
        if (n != 0) begin
            $display("FAIL reset_no_done: scan_done pulses=%0d, required 0", n);
            errors++;
        end
    endtask

    task automatic test_fire_move();
        logic ok;
        int nv;
        do_reset();
        shoot(80, 60, 2'b01, 2'b00);
        checks++;
        if (fire_ack !== 1 || fire_slot !== 3'd0 || active !== 8'h01) begin
            $display("FAIL first_fire: ack=%b slot=%0d active=%h, required 1 0 01", fire_ack, fire_slot, active);
            errors++;
        end
        step();
        checks++;
        if (fire_ack !== 0) begin
            $display("FAIL ack_pulse: ack=%b, required 0", fire_ack);
            errors++;
        end
        step_to(30);
        scan_start = 1;
        step();
        scan_start = 0;
        wait_valid(ok);
        checks++;
        if (!ok || plot_x !== 8'd83 || plot_y !== 7'd60 || plot_slot !== 3'd0) begin
            $display("FAIL move_3_ticks: valid=%b x=%0d y=%0d slot=%0d, required 1 83 60 0", ok, plot_x, plot_y, plot_slot);
            errors++;
        end
        plot_ready = 1;
        step();
        plot_ready = 0;
        wait_done(ok, nv);
        checks++;
        if (!ok || nv != 0 || scan_busy !== 0) begin
            $display("FAIL scan1_done: done=%b extra_valid=%0d busy=%b, required 1 0 0", ok, nv, scan_busy);
            errors++;
        end
    endtask

    task automatic test_fill_drop();
        do_reset();
        fire = 1; fire_x = 8'd10; fire_y = 7'd10; fire_dx = 2'b00; fire_dy = 2'b00;
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (i < 8) begin
                if (fire_ack !== 1 || fire_drop !== 0 || fire_slot !== 3'(i)) begin
                    $display("FAIL fill_ack_%0d: ack=%b drop=%b slot=%0d, required 1 0 %0d", i, fire_ack, fire_drop, fire_slot, i);
                    errors++;
                end
            end else if (fire_drop !== 1 || fire_ack !== 0) begin
                $display("FAIL fill_drop: ack=%b drop=%b, required 0 1", fire_ack, fire_drop);
                errors++;
            end
        end
        fire = 0;
        checks++;
        if (full !== 1 || active !== 8'hFF) begin
            $display("FAIL full_flag: full=%b active=%h, required 1 ff", full, active);
            errors++;
        end
        kill = 1; kill_slot = 3'd3; fire = 1;
        step();
        checks++;
        if (fire_drop !== 1 || fire_ack !== 0 || active !== 8'hF7 || full !== 0) begin
            $display("FAIL kill_same_cycle_fire: drop=%b ack=%b active=%h full=%b, required 1 0 f7 0", fire_drop, fire_ack, active, full);
            errors++;
        end
        step();
        kill = 0; fire = 0;
        checks++;
        if (fire_ack !== 1 || fire_slot !== 3'd3 || active !== 8'hFF) begin
            $display("FAIL refill_slot3: ack=%b slot=%0d active=%h, required 1 3 ff", fire_ack, fire_slot, active);
            errors++;
        end
    endtask

    task automatic test_edges();
        logic ok;
        int nv;
        do_reset();
        shoot(158, 50, 2'b01, 2'b00);
        shoot(5, 119, 2'b00, 2'b01);
        shoot(0, 3, 2'b10, 2'b00);
        shoot(160, 10, 2'b00, 2'b00);
        checks++;
        if (fire_drop !== 1 || fire_ack !== 0) begin
            $display("FAIL range_x_drop: drop=%b ack=%b, required 1 0", fire_drop, fire_ack);
            errors++;
        end
        shoot(10, 120, 2'b00, 2'b00);
        checks++;
        if (fire_drop !== 1 || active !== 8'h07) begin
            $display("FAIL range_y_drop: drop=%b active=%h, required 1 07", fire_drop, active);
            errors++;
        end
        step_to(10);
        checks++;
        if (active !== 8'h01) begin
            $display("FAIL edge_first_tick: active=%h, required 01", active);
            errors++;
        end
        scan_start = 1; plot_ready = 1;
        step();
        scan_start = 0;
        wait_valid(ok);
        checks++;
        if (!ok || plot_x !== 8'd159 || plot_slot !== 3'd0) begin
            $display("FAIL edge_moved_to_max: valid=%b x=%0d slot=%0d, required 1 159 0", ok, plot_x, plot_slot);
            errors++;
        end
        step();
        wait_done(ok, nv);
        plot_ready = 0;
        step_to(20);
        checks++;
        if (active !== 8'h00) begin
            $display("FAIL edge_retire: active=%h, required 00", active);
            errors++;
        end
        scan_start = 1;
        step();
        scan_start = 0;
        wait_done(ok, nv);
        checks++;
        if (!ok || nv != 0) begin
            $display("FAIL edge_no_entry: done=%b valid_cycles=%0d, required 1 0", ok, nv);
            errors++;
        end
    endtask

    task automatic test_lifetime();
        do_reset();
        shoot(20, 20, 2'b00, 2'b11);
        step_to(40);
        checks++;
        if (l_active !== 8'h01) begin
            $display("FAIL life_after_4: active=%h, required 01", l_active);
            errors++;
        end
        step_to(49);
        checks++;
        if (l_active !== 8'h01) begin
            $display("FAIL life_before_5: active=%h, required 01", l_active);
            errors++;
        end
        step_to(50);
        checks++;
        if (l_active !== 8'h00 || active !== 8'h01) begin
            $display("FAIL life_retire_5: short=%h long=%h, required 00 01", l_active, active);
            errors++;
        end
    endtask

    task automatic test_scan_stall();
        logic ok, stable;
        int nv, s;
        do_reset();
        for (int i = 0; i < 7; i++) shoot(10 + 10 * i, 5 + i, 2'b00, 2'b00);
        kill = 1;
        kill_slot = 3'd0; step();
        kill_slot = 3'd2; step();
        kill_slot = 3'd3; step();
        kill_slot = 3'd5; step();
        kill = 0;
        checks++;
        if (active !== 8'h52) begin
            $display("FAIL scan_setup: active=%h, required 52", active);
            errors++;
        end
        scan_start = 1;
        step();
        scan_start = 0;
        for (int e = 0; e < 3; e++) begin
            s = (e == 0) ? 1 : (e == 1) ? 4 : 6;
            wait_valid(ok);
            checks++;
            if (!ok || plot_slot !== 3'(s) || plot_x !== 8'(10 + 10 * s) || plot_y !== 7'(5 + s)) begin
                $display("FAIL scan_entry_%0d: valid=%b slot=%0d x=%0d y=%0d, required 1 %0d %0d %0d",
                         e, ok, plot_slot, plot_x, plot_y, s, 10 + 10 * s, 5 + s);
                errors++;
            end
            stable = 1;
            for (int c = 0; c < 5; c++) begin
                if (c == 1) scan_start = 1;
                if (e == 2 && c == 0) begin kill = 1; kill_slot = 3'd6; end
                step();
                scan_start = 0; kill = 0;
                if (!plot_valid || !scan_busy || plot_slot !== 3'(s) || plot_x !== 8'(10 + 10 * s) || plot_y !== 7'(5 + s))
                    stable = 0;
            end
            checks++;
            if (!stable) begin
                $display("FAIL scan_hold_%0d: valid=%b slot=%0d x=%0d y=%0d, required 1 %0d %0d %0d",
                         e, plot_valid, plot_slot, plot_x, plot_y, s, 10 + 10 * s, 5 + s);
                errors++;
            end
            plot_ready = 1;
            step();
            plot_ready = 0;
        end
        wait_done(ok, nv);
        checks++;
        if (!ok || nv != 0 || scan_busy !== 0 || active !== 8'h12) begin
            $display("FAIL scan_done: done=%b extra_valid=%0d busy=%b active=%h, required 1 0 0 12", ok, nv, scan_busy, active);
            errors++;
        end
        nv = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (scan_done || plot_valid) nv++;
        end
        checks++;
        if (nv != 0) begin
            $display("FAIL scan_single_pulse: extra done/valid cycles=%0d, required 0", nv);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        int ex;
        do_reset();
        shoot(10, 50, 2'b01, 2'b00);
        shoot(20, 50, 2'b01, 2'b00);
        shoot(30, 50, 2'b01, 2'b00);
        step_to(9);
        kill = 1; kill_slot = 3'd2;
        shoot(100, 50, 2'b01, 2'b00);
        kill = 0;
        checks++;
        if (fire_ack !== 1 || fire_slot !== 3'd3 || active !== 8'h0B) begin
            $display("FAIL tick_kill_fire: ack=%b slot=%0d active=%h, required 1 3 0b", fire_ack, fire_slot, active);
            errors++;
        end
        shoot(70, 50, 2'b01, 2'b00);
        checks++;
        if (fire_ack !== 1 || fire_slot !== 3'd2 || active !== 8'h0F) begin
            $display("FAIL reuse_slot2: ack=%b slot=%0d active=%h, required 1 2 0f", fire_ack, fire_slot, active);
            errors++;
        end
        scan_start = 1;
        step();
        scan_start = 0;
        for (int e = 0; e < 4; e++) begin
            ex = (e == 0) ? 11 : (e == 1) ? 21 : (e == 2) ? 70 : 100;
            wait_valid(ok);
            checks++;
            if (!ok || plot_slot !== 3'(e) || plot_x !== 8'(ex) || plot_y !== 7'd50) begin
                $display("FAIL b2b_entry_%0d: valid=%b slot=%0d x=%0d y=%0d, required 1 %0d %0d 50",
                         e, ok, plot_slot, plot_x, plot_y, e, ex);
                errors++;
            end
            plot_ready = 1;
            step();
            plot_ready = 0;
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_fire_move();
        test_fill_drop();
        test_edges();
        test_lifetime();
        test_scan_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
- Parametrised pool of NUM_BULLETS independent projectiles for the Asteroids datapath; replaces per-bullet instantiation with a single slot-allocated store.
- Accepts fire requests from the ship controller, allocates the lowest free slot, and advances all live bullets on a shared move tick.
- Retires bullets at the screen edge, on lifetime expiry, or on a collision kill.
- Streams live bullet coordinates to the VGA plotter through a valid/ready scan port.

Parameters:
NUM_BULLETS, 8, number of slots (2..64)
SLOT_W, 3, slot index width; must satisfy 2**SLOT_W >= NUM_BULLETS
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
X_MAX, 159, largest legal x
Y_MAX, 119, largest legal y
MOVE_DIV, 10, clk cycles per move tick (>=2)
LIFETIME, 64, moves before forced retirement (>=1, fits 8 bits)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
fire  in  1  fire request, sampled every cycle
fire_x  in  X_W  start x
fire_y  in  Y_W  start y
fire_dx  in  2  00 hold, 01 +1, 10 -1, 11 hold
fire_dy  in  2  same encoding as fire_dx
fire_ack  out  1  one-cycle pulse: request accepted
fire_slot  out  SLOT_W  slot index allocated; valid with fire_ack
fire_drop  out  1  one-cycle pulse: request rejected
kill  in  1  collision retire strobe
kill_slot  in  SLOT_W  slot to retire
active  out  NUM_BULLETS  per-slot live bits
full  out  1  all slots live
scan_start  in  1  begin plot scan
scan_busy  out  1  scan in progress
plot_valid  out  1  plot entry presented
plot_ready  in  1  plotter accepts entry
plot_x  out  X_W  bullet x
plot_y  out  Y_W  bullet y
plot_slot  out  SLOT_W  bullet slot
scan_done  out  1  one-cycle pulse: scan finished

Behaviour:
- Reset: active=0; all slot state=0; tick counter=0; scan FSM=IDLE. All outputs are 0. A reset during a scan aborts it with no scan_done.
- Tick: counter runs 0..MOVE_DIV-1 and wraps. The internal tick is high in the cycle where counter==MOVE_DIV-1.
- Fire at cycle t, decided against active as it stands at t:
  - Free slot exists and fire_x<=X_MAX and fire_y<=Y_MAX: the lowest-index free slot loads x, y, dx, dy and life=LIFETIME, and its active bit sets at t+1. fire_ack=1 and fire_slot=index at t+1.
  - Otherwise: fire_drop=1 at t+1 and no state change.
- Tick processing for each active slot, in priority order:
  1. kill for this slot in the same cycle: retire.
  2. life==0: retire.
  3. Would leave the screen (x==0&&dx==10, x==X_MAX&&dx==01, y==0&&dy==10, y==Y_MAX&&dy==01): retire with no move.
  4. Otherwise: apply dx and dy, life-=1.
  - A stationary bullet (00/11 on both axes) retires by lifetime only.
- Kill: when kill is high and kill_slot is active, that slot clears at the next edge. A kill to an inactive or out-of-range slot is ignored.
- Simultaneous events:
  - A slot retiring at cycle t is not reusable by a fire at t; it is reusable from t+1.
  - A bullet loaded on a tick cycle is not moved by that tick; its first move is on the next tick.
- full = (active == all ones), combinational from the active register.
- Scan FSM states:
  - IDLE: scan_start moves to SCAN with idx=0 and scan_busy=1.
  - SCAN, inactive idx: advance one slot per cycle.
  - SCAN, active idx: capture x, y, idx into the plot registers, set plot_valid=1, go to WAIT.
  - WAIT: hold plot_x, plot_y and plot_slot stable while !plot_ready. On plot_ready, clear plot_valid and advance idx.
  - After slot NUM_BULLETS-1 is finished: scan_done=1 for one cycle, scan_busy=0, back to IDLE.
  - scan_start while busy is ignored.
  - Captured coordinates are a snapshot; movement or retirement of that slot during WAIT does not alter or cancel the presented entry.
  - Moves, fires and kills are never stalled by the scan.
- Coordinate arithmetic is modulo the field width. Out-of-range results cannot occur because edge retirement precedes any move.

Test Plan:
- Reset, then fire x=80 y=60 dx=01 dy=00 -> fire_ack=1 and fire_slot=0 one cycle later, active=0x01. After 3 ticks (30 cycles) the scan presents x=83 y=60.
- 9 fires on consecutive cycles with NUM_BULLETS=8 -> slots 0..7 acked, full=1, 9th gives fire_drop=1. kill slot 3 then fire -> fire_slot=3.
- Fire at x=158 dx=01 -> moves to 159 on the first tick and retires on the second tick. Active bit clears, no plot entry with x=160 ever appears.
- LIFETIME=4, stationary bullet -> still active after 4 ticks, retired on the 5th tick.
- Slots 1, 4, 6 live, scan_start with plot_ready low for 5 cycles per entry -> three entries in slot order. Each entry is held stable through its stall. scan_done pulses once after slot 7, and a scan_start during the scan is ignored.
- Kill of slot 2 coincident with a tick and a fire while slots 0..2 are live -> slot 2 retires and is not moved, and the fire gets slot 3. The next fire gets slot 2.
